// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak widths, squeeze FSM states and byte-reversal helper
package keccak_pkg;
    localparam int LANE_W    = 64;
    localparam int STATE_W   = 1600;
    localparam int RATE_W    = 576;
    localparam int MAX_LANES = 9;
    localparam int CNT_W     = 4;

    typedef enum logic {IDLE, SEND} sq_state_t;

    function automatic logic [LANE_W-1:0] bswap64(input logic [LANE_W-1:0] x);
        logic [LANE_W-1:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = x[LANE_W-8-8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/lane_byteswap.sv
// lane_byteswap: combinational byte reversal of one 64-bit lane (byte 0 -> bits 63:56)
module lane_byteswap
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] din,
    output logic [LANE_W-1:0] dout
);
    assign dout = bswap64(din);
endmodule

// File: rtl/digest_squeeze.sv
// digest_squeeze: buffers the rate lanes of a permuted Keccak state and streams them out one 64-bit lane per handshake.
// Build option: KECCAK_DIGEST_BYTESWAP_EN reverses the byte order of every emitted lane.
module digest_squeeze
    import keccak_pkg::*;
#(
    parameter int DIGEST_WORDS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_valid,
    output logic               state_ready,
    output logic [LANE_W-1:0]  dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy
);
    sq_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RATE_W-1:0]  buf_q, buf_d;
    logic [LANE_W-1:0]  lane_raw, lane_out;
    logic               last_lane;
    logic               unused_ok;

    assign unused_ok = ^state_in;
    assign lane_raw  = buf_q[cnt_q*LANE_W +: LANE_W];
    assign last_lane = cnt_q == CNT_W'(DIGEST_WORDS-1);

`ifdef KECCAK_DIGEST_BYTESWAP_EN
    lane_byteswap u_swap (.din(lane_raw), .dout(lane_out));
`else
    assign lane_out = lane_raw;
`endif

    assign state_ready = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign dout_valid  = state_q == SEND;
    assign dout_last   = dout_valid && last_lane;
    assign dout        = dout_valid ? lane_out : '0;

    // Next state: capture in IDLE, step the lane counter on each accepted beat in SEND
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (state_q == IDLE) begin
            if (state_valid) begin
                for (int i = 0; i < MAX_LANES; i++)
                    buf_d[i*LANE_W +: LANE_W] = (i < DIGEST_WORDS) ? state_in[i*LANE_W +: LANE_W] : '0;
                cnt_d   = '0;
                state_d = SEND;
            end
        end else if (dout_ready) begin
            state_d = last_lane ? IDLE : SEND;
            cnt_d   = last_lane ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // State, counter and lane buffer registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: doc/digest_squeeze.md
DIGEST_SQUEEZE -- requirements
Module: digest_squeeze

Interface
REQ-001 SHALL have parameter DIGEST_WORDS, default 8, number of 64-bit digest lanes emitted per state (legal 1..9; rate 576 bits = 9 lanes).
REQ-002 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port state_in, input, 1600, permuted Keccak state; lane i = state_in[64*i+63 : 64*i].
REQ-005 SHALL have port state_valid, input, 1, state_in holds a finished permutation.
REQ-006 SHALL have port state_ready, output, 1, block can capture a state this cycle.
REQ-007 SHALL have port dout, output, 64, current digest lane.
REQ-008 SHALL have port dout_valid, output, 1, dout holds a valid lane.
REQ-009 SHALL have port dout_ready, input, 1, downstream accepts dout this cycle.
REQ-010 SHALL have port dout_last, output, 1, current lane is lane DIGEST_WORDS-1.
REQ-011 SHALL have port busy, output, 1, high whenever not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE and SEND only.
REQ-013 SHALL drive state_ready = 1 in IDLE, 0 in SEND (decoded from state register, no combinational path from dout_ready).
REQ-014 SHALL, in IDLE with state_valid=1, capture lanes 0..DIGEST_WORDS-1 of state_in into an internal buffer, clear lane counter to 0, enter SEND next cycle.
REQ-015 SHALL ignore state_in changes after capture; buffer is the only source of dout.
REQ-016 SHALL, in SEND, drive dout = buffer lane[cnt] and dout_valid = 1; dout SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-017 SHALL advance cnt by 1 on each cycle with dout_valid=1 and dout_ready=1 (transfer).
REQ-018 SHALL assert dout_last = 1 exactly when in SEND and cnt = DIGEST_WORDS-1.
REQ-019 SHALL, on transfer with dout_last=1, return to IDLE next cycle; state_ready SHALL rise that cycle (one bubble cycle minimum between last beat and next capture).
REQ-020 SHALL hold dout_valid = 0 and dout = 0 in IDLE.
REQ-021 SHALL size cnt as 4 bits; cnt never exceeds DIGEST_WORDS-1 (no wrap-around past last lane).
REQ-022 SHALL, with DIGEST_WORDS=1, present one beat with dout_last=1 on the first SEND cycle.
REQ-023 SHALL ignore state_valid while in SEND (no queued capture).

Reset
REQ-024 SHALL, on reset=1 at a clk edge, enter IDLE, clear cnt and buffer; outputs next cycle: state_ready=1, dout_valid=0, dout=0, dout_last=0, busy=0.
REQ-025 SHALL, on reset during SEND, abandon the digest immediately; no further beats of that state are emitted.
REQ-026 SHALL give reset priority over state_valid and dout_ready in the same cycle.

Configuration
REQ-027 SHALL honour macro KECCAK_DIGEST_BYTESWAP_EN: defined -> dout is the buffered lane with its 8 bytes reversed (byte 0 to dout[63:56]); undefined -> dout is the lane unchanged (byte 0 on dout[7:0]).
REQ-028 SHALL keep handshake timing identical with and without the macro.

Structure
REQ-029 SHALL take LANE_W=64, STATE_W=1600, RATE_W=576, MAX_LANES=9 and the FSM state enum from shared package keccak_pkg.
REQ-030 SHALL place the byte reversal in one sub-module lane_byteswap (64-bit in/out, combinational), instantiated only under KECCAK_DIGEST_BYTESWAP_EN.

Verification
REQ-031 SHALL test basic squeeze: state_in lane i = 64'h1111_1111_1111_1111*(i+1), state_valid 1 cycle, dout_ready=1 -> 8 consecutive beats 0x1111..11 .. 0x8888..88, dout_last on beat 8, state_ready high one cycle later.
REQ-032 SHALL test backpressure: dout_ready low for 3 cycles at beat 2 -> dout held at lane 2 value, dout_valid held 1, no beat lost or duplicated.
REQ-033 SHALL test reset mid-digest: reset at beat 4 -> next cycle dout_valid=0, state_ready=1, busy=0; new state then emits from lane 0.
REQ-034 SHALL test capture isolation: state_in changed every cycle during SEND, state_valid held 1 -> emitted lanes match captured state; second capture only after IDLE.
REQ-035 SHALL test byteswap: lane0 = 64'h0011_2233_4455_6677 -> dout 64'h7766_5544_3322_1100 with macro, unchanged without.
REQ-036 SHALL test DIGEST_WORDS=1 and 9: exactly 1 and 9 beats, dout_last on the final beat only.
